// File: rtl/multiphase_strobe_gen.sv
// Purpose : programmable-period clock divider emitting PHASES non-overlapping one-clock strobes per period, steerable by DPLL advance/retard requests.
// Latency : ph and wrap are registered; each is high the cycle after the edge that sampled the decoding counter value.
// Backpr. : none; en=0 freezes the count and suppresses strobes, while adv/ret requests are still captured.
//
// Ports:
//   clk32      system clock
//   rst_n      asynchronous reset, active low
//   en         count enable
//   div_ratio  requested period in clocks (values below 2 act as 2), sampled only at period end
//   adv / ret  single-cycle requests to shorten / lengthen the next-completing period by one clock
//   ph         per-phase strobes, phase k fires when the count equals k*PH_STEP
//   wrap       one-clock marker of the cycle in which the count has returned to 0
//   cnt_o      current counter value, for observation
module multiphase_strobe_gen #(
   parameter int DIV_W   = 8,
   parameter int PHASES  = 2,
   parameter int PH_STEP = 2,
   parameter int DEF_DIV = 4
) (
   input  logic              clk32,
   input  logic              rst_n,
   input  logic              en,
   input  logic [DIV_W-1:0]  div_ratio,
   input  logic              adv,
   input  logic              ret,
   output logic [PHASES-1:0] ph,
   output logic              wrap,
   output logic [DIV_W-1:0]  cnt_o
);

   localparam logic [DIV_W-1:0] ONE     = DIV_W'(1);
   localparam logic [DIV_W-1:0] MIN_PER = DIV_W'(2);
   localparam logic [DIV_W-1:0] DEF_PER = (DEF_DIV < 2) ? MIN_PER : DIV_W'(DEF_DIV);

   logic [DIV_W-1:0]  cnt_q, cnt_d;
   logic [DIV_W-1:0]  per_q, per_d;
   logic              adv_p_q, adv_p_d;
   logic              ret_p_q, ret_p_d;
   logic [PHASES-1:0] ph_q, ph_d;
   logic              wrap_q, wrap_d;

   logic [DIV_W-1:0]  term;
   logic [DIV_W-1:0]  div_sat;
   logic              wrap_evt;
   logic              req_adv, req_ret;
   logic [PHASES-1:0] ph_hit;

   // Terminal count for the period in progress. A lone advance drops one
   // clock (floored at 1 so the period never collapses below 2 clocks), a
   // lone retard adds one, and both pending cancel each other out.
   always_comb begin
      term = per_q - ONE;
      if (adv_p_q && !ret_p_q) begin
         term = (per_q > MIN_PER) ? (per_q - MIN_PER) : ONE;
      end else if (ret_p_q && !adv_p_q) begin
         term = per_q;
      end
   end

   // A late advance can pull the terminal count below a value the counter
   // has already reached; ">=" ends the period there instead of letting the
   // counter run round the whole DIV_W range.
   assign wrap_evt = en && (cnt_q >= term);

   assign div_sat  = (div_ratio < MIN_PER) ? MIN_PER : div_ratio;

   // Contradictory requests in one cycle are dropped altogether.
   assign req_adv  = adv && !ret;
   assign req_ret  = ret && !adv;

   // Phase offsets are fixed at elaboration; an offset the counter can never
   // represent is tied off rather than aliased onto a truncated value.
   for (genvar k = 0; k < PHASES; k++) begin : g_phase
      localparam longint unsigned OFF   = longint'(k) * longint'(PH_STEP);
      localparam bit              FITS  = (DIV_W >= 63) || (OFF < (64'd1 << DIV_W));
      localparam logic [DIV_W-1:0] OFF_W = DIV_W'(OFF);
      assign ph_hit[k] = FITS && (cnt_q == OFF_W);
   end

   always_comb begin
      cnt_d   = cnt_q;
      per_d   = per_q;
      wrap_d  = 1'b0;
      ph_d    = {PHASES{en}} & ph_hit;
      // Flags clear at the period end first, so a request landing on the
      // wrap cycle is carried into the following period.
      adv_p_d = (adv_p_q && !wrap_evt) || req_adv;
      ret_p_d = (ret_p_q && !wrap_evt) || req_ret;
      if (en) begin
         if (wrap_evt) begin
            cnt_d  = '0;
            per_d  = div_sat;
            wrap_d = 1'b1;
         end else begin
            cnt_d  = cnt_q + ONE;
         end
      end
   end

   always_ff @(posedge clk32 or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q   <= '0;
         per_q   <= DEF_PER;
         adv_p_q <= 1'b0;
         ret_p_q <= 1'b0;
         ph_q    <= '0;
         wrap_q  <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         per_q   <= per_d;
         adv_p_q <= adv_p_d;
         ret_p_q <= ret_p_d;
         ph_q    <= ph_d;
         wrap_q  <= wrap_d;
      end
   end

   assign ph    = ph_q;
   assign wrap  = wrap_q;
   assign cnt_o = cnt_q;

endmodule

// File: tb/tb_multiphase_strobe_gen.sv
// Purpose : self-checking bench for multiphase_strobe_gen, default build and a 4-phase/3-step build side by side.
// Latency : outputs are compared on the falling edge against a period-level reference model.
// Backpr. : not applicable; every wait on the design is bounded by a cycle budget.
module tb_multiphase_strobe_gen;

   logic       clk32;
   logic       rst_n;
   logic       en0, adv0, ret0;
   logic [7:0] div0;
   logic       en1, adv1, ret1;
   logic [7:0] div1;
   logic [1:0] ph0;
   logic [3:0] ph1;
   logic       wrap0, wrap1;
   logic [7:0] cnt0, cnt1;

   multiphase_strobe_gen #(
      .DIV_W(8), .PHASES(2), .PH_STEP(2), .DEF_DIV(4)
   ) u_dut0 (
      .clk32(clk32), .rst_n(rst_n), .en(en0), .div_ratio(div0),
      .adv(adv0), .ret(ret0), .ph(ph0), .wrap(wrap0), .cnt_o(cnt0)
   );

   multiphase_strobe_gen #(
      .DIV_W(8), .PHASES(4), .PH_STEP(3), .DEF_DIV(4)
   ) u_dut1 (
      .clk32(clk32), .rst_n(rst_n), .en(en1), .div_ratio(div1),
      .adv(adv1), .ret(ret1), .ph(ph1), .wrap(wrap1), .cnt_o(cnt1)
   );

   initial begin
      clk32 = 1'b0;
      forever #5 clk32 = ~clk32;
   end

   int n_checks = 0;
   int n_pass   = 0;
   int n_fail   = 0;

   // Reference model: position inside the current period, nominal period
   // length and the pending adjustments, evaluated with plain integers.
   int         m_pos [2];
   int         m_nom [2];
   bit         m_a   [2];
   bit         m_r   [2];
   logic [3:0] e_ph  [2];
   logic       e_wrap[2];
   int         e_cnt [2];

   function automatic int n_ph(input int i);
      return (i == 0) ? 2 : 4;
   endfunction

   function automatic int step_of(input int i);
      return (i == 0) ? 2 : 3;
   endfunction

   task automatic model_reset(input int i);
      m_pos[i]  = 0;
      m_nom[i]  = 4;
      m_a[i]    = 0;
      m_r[i]    = 0;
      e_ph[i]   = 4'b0;
      e_wrap[i] = 1'b0;
      e_cnt[i]  = 0;
   endtask

   task automatic model_step(input int i, input logic en_, input logic [7:0] div_,
                             input logic a_, input logic r_);
      int len;
      len = m_nom[i];
      if (m_a[i] && !m_r[i]) len = len - 1;
      if (m_r[i] && !m_a[i]) len = len + 1;
      if (len < 2) len = 2;
      e_ph[i]   = 4'b0;
      e_wrap[i] = 1'b0;
      if (en_) begin
         for (int k = 0; k < n_ph(i); k++)
            if (m_pos[i] == k * step_of(i)) e_ph[i][k] = 1'b1;
         if (m_pos[i] >= len - 1) begin
            e_wrap[i] = 1'b1;
            m_pos[i]  = 0;
            m_nom[i]  = (div_ < 8'd2) ? 2 : int'(div_);
            m_a[i]    = 0;
            m_r[i]    = 0;
         end else begin
            m_pos[i] = m_pos[i] + 1;
         end
      end
      if (a_ && !r_) m_a[i] = 1;
      if (r_ && !a_) m_r[i] = 1;
      e_cnt[i] = m_pos[i];
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk32);
      if (!rst_n) begin
         model_reset(0);
         model_reset(1);
      end else begin
         model_step(0, en0, div0, adv0, ret0);
         model_step(1, en1, div1, adv1, ret1);
      end
      @(negedge clk32);
      chk("ph0",   32'(ph0),   32'(e_ph[0][1:0]));
      chk("wrap0", 32'(wrap0), 32'(e_wrap[0]));
      chk("cnt0",  32'(cnt0),  32'(e_cnt[0]));
      chk("ph1",   32'(ph1),   32'(e_ph[1]));
      chk("wrap1", 32'(wrap1), 32'(e_wrap[1]));
      chk("cnt1",  32'(cnt1),  32'(e_cnt[1]));
   endtask

   task automatic sync_wrap(input int i);
      bit seen;
      seen = 0;
      for (int c = 0; c < 64 && !seen; c++) begin
         cyc();
         if (((i == 0) ? wrap0 : wrap1) === 1'b1) seen = 1;
      end
      chk("sync_wrap", 32'(seen), 32'd1);
   endtask

   // Align to a wrap of instance 0, drive the given requests on the first
   // two cycles, then return the next three wrap-to-wrap intervals.
   task automatic measure(input logic a0, input logic r0, input logic a1, input logic r1,
                          output int i0, output int i1, output int i2);
      int iv[3];
      int n, got;
      iv = '{0, 0, 0};
      n = 0;
      got = 0;
      sync_wrap(0);
      for (int c = 0; c < 60 && got < 3; c++) begin
         adv0 = (c == 0) ? a0 : (c == 1) ? a1 : 1'b0;
         ret0 = (c == 0) ? r0 : (c == 1) ? r1 : 1'b0;
         cyc();
         n++;
         if (wrap0 === 1'b1) begin
            iv[got] = n;
            got++;
            n = 0;
         end
      end
      adv0 = 1'b0;
      ret0 = 1'b0;
      i0 = iv[0];
      i1 = iv[1];
      i2 = iv[2];
   endtask

   initial begin
      int i0, i1, i2;
      int n, p3, w1, w2;
      bit seen;

      rst_n = 1'b0;
      en0 = 1'b0; adv0 = 1'b0; ret0 = 1'b0; div0 = 8'd4;
      en1 = 1'b0; adv1 = 1'b0; ret1 = 1'b0; div1 = 8'd12;
      model_reset(0);
      model_reset(1);
      repeat (2) @(negedge clk32);
      chk("rst_ph0",   32'(ph0),   32'd0);
      chk("rst_wrap0", 32'(wrap0), 32'd0);
      chk("rst_cnt0",  32'(cnt0),  32'd0);
      chk("rst_ph1",   32'(ph1),   32'd0);

      // Default quadrature: ph[0] in cycle 1, ph[1] in cycle 3.
      rst_n = 1'b1;
      en0 = 1'b1;
      en1 = 1'b1;
      cyc();
      chk("first_ph0", 32'(ph0), 32'h1);
      cyc();
      cyc();
      chk("third_ph1", 32'(ph0), 32'h2);
      cyc();
      chk("wrap_cycle4", 32'(wrap0), 32'd1);

      measure(1'b0, 1'b0, 1'b0, 1'b0, i0, i1, i2);
      chk("nominal_iv0", 32'(i0), 32'd4);
      chk("nominal_iv1", 32'(i1), 32'd4);
      chk("nominal_iv2", 32'(i2), 32'd4);

      measure(1'b1, 1'b0, 1'b0, 1'b0, i0, i1, i2);
      chk("adv_iv0", 32'(i0), 32'd3);
      chk("adv_iv1", 32'(i1), 32'd4);
      chk("adv_iv2", 32'(i2), 32'd4);

      measure(1'b0, 1'b1, 1'b0, 1'b0, i0, i1, i2);
      chk("ret_iv0", 32'(i0), 32'd5);
      chk("ret_iv1", 32'(i1), 32'd4);

      measure(1'b1, 1'b1, 1'b0, 1'b0, i0, i1, i2);
      chk("advret_same_iv0", 32'(i0), 32'd4);
      chk("advret_same_iv1", 32'(i1), 32'd4);

      measure(1'b1, 1'b0, 1'b0, 1'b1, i0, i1, i2);
      chk("adv_then_ret_iv0", 32'(i0), 32'd4);
      chk("adv_then_ret_iv1", 32'(i1), 32'd4);

      // Degenerate ratios clamp to a 2-clock period; advance cannot shrink it.
      div0 = 8'd0;
      sync_wrap(0);
      sync_wrap(0);
      measure(1'b1, 1'b0, 1'b0, 1'b0, i0, i1, i2);
      chk("div0_adv_iv0", 32'(i0), 32'd2);
      chk("div0_adv_iv1", 32'(i1), 32'd2);
      div0 = 8'd1;
      measure(1'b0, 1'b0, 1'b0, 1'b0, i0, i1, i2);
      chk("div1_iv0", 32'(i0), 32'd2);
      chk("div1_iv2", 32'(i2), 32'd2);
      div0 = 8'd4;
      sync_wrap(0);
      sync_wrap(0);

      // Enable held low mid-period: count frozen, strobes silent, then resumes.
      sync_wrap(0);
      cyc();
      en0 = 1'b0;
      for (int c = 0; c < 5; c++) begin
         cyc();
         chk("en_lo_cnt",  32'(cnt0),  32'd1);
         chk("en_lo_wrap", 32'(wrap0), 32'd0);
         chk("en_lo_ph",   32'(ph0),   32'd0);
      end
      en0 = 1'b1;
      n = 0;
      seen = 0;
      for (int c = 0; c < 20 && !seen; c++) begin
         cyc();
         n++;
         if (wrap0 === 1'b1) seen = 1;
      end
      chk("en_resume_iv", 32'(n), 32'd3);

      // Four phases at 3-clock spacing, period 12, then 8 with ph[3] absent.
      sync_wrap(1);
      sync_wrap(1);
      p3 = 0; w1 = 0; w2 = 0; n = 0;
      for (int c = 0; c < 40 && w2 == 0; c++) begin
         if (c == 2) div1 = 8'd8;
         cyc();
         n++;
         if (ph1[3] === 1'b1) p3++;
         if (wrap1 === 1'b1) begin
            if (w1 == 0) w1 = n;
            else w2 = n;
         end
      end
      chk("p4_iv12", 32'(w1), 32'd12);
      chk("p4_iv8",  32'(w2), 32'd20);
      chk("p4_ph3_count", 32'(p3), 32'd1);

      // Asynchronous reset at cnt=2 with an advance pending.
      sync_wrap(0);
      adv0 = 1'b1;
      cyc();
      adv0 = 1'b0;
      cyc();
      chk("pre_rst_cnt0", 32'(cnt0), 32'd2);
      #2 rst_n = 1'b0;
      #1;
      model_reset(0);
      model_reset(1);
      chk("async_ph0",   32'(ph0),   32'd0);
      chk("async_wrap0", 32'(wrap0), 32'd0);
      chk("async_cnt0",  32'(cnt0),  32'd0);
      chk("async_ph1",   32'(ph1),   32'd0);
      chk("async_cnt1",  32'(cnt1),  32'd0);
      cyc();
      rst_n = 1'b1;
      n = 0;
      seen = 0;
      for (int c = 0; c < 20 && !seen; c++) begin
         cyc();
         n++;
         if (wrap0 === 1'b1) seen = 1;
      end
      chk("post_rst_iv", 32'(n), 32'd4);

      // Randomised traffic against the model.
      for (int c = 0; c < 500; c++) begin
         en0  = ($urandom_range(9) != 0);
         adv0 = ($urandom_range(6) == 0);
         ret0 = ($urandom_range(6) == 0);
         en1  = ($urandom_range(9) != 0);
         adv1 = ($urandom_range(6) == 0);
         ret1 = ($urandom_range(6) == 0);
         if ($urandom_range(15) == 0) div0 = 8'($urandom_range(9));
         if ($urandom_range(15) == 0) div1 = 8'($urandom_range(16));
         cyc();
      end
      adv0 = 1'b0; ret0 = 1'b0; adv1 = 1'b0; ret1 = 1'b0;
      cyc();

      if (n_fail != 0) $display("%0d comparisons did not match", n_fail);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/multiphase_strobe_gen.md
# multiphase_strobe_gen

Parametrised multi-phase strobe generator for the bit-synchronisation loops. It divides the system clock into a programmable sample period and emits PHASES one-cycle, non-overlapping strobes at fixed offsets within each period. It also accepts advance/retard requests that shorten or lengthen a single period by one clock, so a DPLL phase detector can steer sampling phase directly. With default parameters it produces the standard 4-cycle, two-phase quadrature enables used by the existing demodulators.

## Interface
Parameters:
- DIV_W, 8, width of period counter and div_ratio
- PHASES, 2, number of strobe outputs
- PH_STEP, 2, spacing in clocks between consecutive phase offsets (phase k offset = k*PH_STEP)
- DEF_DIV, 4, period loaded at reset (must be ≥2)

Ports:
- clk32  in  1  system clock
- rst_n  in  1  asynchronous reset, active low
- en  in  1  count enable
- div_ratio  in  DIV_W  requested period in clocks; values <2 treated as 2
- adv  in  1  single-cycle request: shorten next-completing period by 1 clock
- ret  in  1  single-cycle request: lengthen next-completing period by 1 clock
- ph  out  PHASES  phase strobes, one clock wide
- wrap  out  1  one-clock strobe marking end of a period
- cnt_o  out  DIV_W  current counter value (debug/observe)

## Operation
- Registers: cnt (DIV_W), per_q (DIV_W), adv_p, ret_p (pending flags), ph (PHASES), wrap.
- Reset (rst_n low, async): cnt=0, per_q=DEF_DIV, adv_p=ret_p=0, ph=0, wrap=0, cnt_o=0.
- Terminal count T = per_q-1, adjusted: adv_p&!ret_p → per_q-2 (but never below 1); ret_p&!adv_p → per_q; both or neither → per_q-1.
- Each edge with en=1: if cnt==T then cnt<=0, per_q<=max(div_ratio,2), adv_p<=0, ret_p<=0, wrap<=1; else cnt<=cnt+1, wrap<=0.
- ph[k] <= en && (cnt == k*PH_STEP), for each k; phases whose offset exceeds T never fire that period.
- Requests: adv (ret) sets adv_p (ret_p) unless the same cycle is a wrap cycle, in which case the request applies to the following period (flag set after clear). adv and ret asserted in the same cycle: both ignored. Repeat requests while a flag is pending: ignored (max one adjust of each per period). Both flags pending at wrap: cancel, nominal period.
- en=0: cnt, per_q, flags hold; ph and wrap driven 0 next edge; adv/ret still latched.
- div_ratio is sampled only at wrap; mid-period changes never truncate the current period.
- Widths: all comparisons unsigned DIV_W; k*PH_STEP evaluated at elaboration, offsets ≥2^DIV_W never fire.

## Timing
- Period length = T+1 clocks; nominal = per_q.
- ph[k] is high exactly one cycle, the cycle after the edge that sampled cnt==k*PH_STEP with en=1 (1-cycle decode latency).
- wrap is high the cycle in which cnt has just returned to 0; coincident with nothing else except ph[0] decode of the next cycle (ph[0] rises one cycle after wrap).
- First edge after rst_n rises with en=1 samples cnt=0: ph[0] high in cycle 1, ph[1] (defaults) high in cycle 3, repeating every 4.
- Adjust takes effect in the period in progress at the time of request; visible as one shortened/lengthened wrap interval.
- Reset mid-period: all outputs drop to 0 immediately (async), pending requests discarded, restart from cnt=0 with DEF_DIV.

## Test plan
- Defaults, en=1 after reset, div_ratio=4 -> ph[0] every 4 clocks, ph[1] exactly 2 clocks after ph[0], never overlapping; wrap 1 clock before each ph[0].
- PHASES=4, PH_STEP=3, div_ratio=12 -> strobes ph0..ph3 at 3-clock spacing, period 12; change div_ratio to 8 mid-period -> current period stays 12, next is 8 and ph[3] (offset 9) absent.
- Single adv pulse, div=4 -> one wrap interval of 3, then 4s; single ret -> one interval of 5; adv+ret same cycle -> all intervals 4; adv then ret in same period -> interval 4.
- div_ratio=0 or 1 -> period 2; adv at period 2 -> interval stays 2.
- en low for 5 clocks mid-period -> ph/wrap 0, cnt_o frozen, sequence resumes from held count with no lost or extra strobes.
- rst_n asserted at cnt=2 with adv_p set -> ph, wrap, cnt_o 0 immediately; after release period 4, no adjustment applied.
